// File: rtl/id_stage.sv
// Decode stage: register file with write-first bypass, two-byte instruction assembly,
// sticky halt and the registered ID/EX bundle. Optional interrupt injection under `IRQ_EN.
module id_stage #(
   parameter logic [7:0] SP_RESET    = 8'hFF,
   parameter logic [3:0] TWO_BYTE_OP = 4'hC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ir,
   input  logic       stall,
   input  logic       flush,
   input  logic       wb_en,
   input  logic [1:0] wb_addr,
   input  logic [7:0] wb_data,
   input  logic       int_req,
   output logic       if_hold,
   output logic       ex_valid,
   output logic [3:0] ex_opcode,
   output logic [1:0] ex_ra,
   output logic [1:0] ex_rb,
   output logic [7:0] ex_ra_val,
   output logic [7:0] ex_rb_val,
   output logic [7:0] ex_imm,
   output logic       ex_int,
   output logic       hlt
);

   typedef enum logic [0:0] {NORMAL = 1'b0, IMM = 1'b1} state_t;

   state_t     state_r, state_s;
   logic [7:0] regs_r [4];
   logic [7:0] ra_rd_s, rb_rd_s, r3_rd_s;
   logic [7:0] first_r, first_s;
   logic [7:0] lat_ra_r, lat_ra_s, lat_rb_r, lat_rb_s;
   logic       hlt_r, hlt_s;
   logic       inject_s;
   logic       ex_valid_s, ex_int_s;
   logic [3:0] ex_opcode_s;
   logic [1:0] ex_ra_s, ex_rb_s;
   logic [7:0] ex_ra_val_s, ex_rb_val_s, ex_imm_s;

`ifdef IRQ_EN
   logic int_pending_r;

   // Pending interrupt: set whenever requested, cleared by the injection that consumes it
   always_ff @(posedge clk) begin
      if (!rst) begin
         int_pending_r <= 1'b0;
      end else begin
         int_pending_r <= int_req | (int_pending_r & ~inject_s);
      end
   end

   assign inject_s = int_pending_r & (state_r == NORMAL) & ~stall & ~flush & ~hlt_r;
`else
   logic int_unused_s;
   assign int_unused_s = int_req;
   assign inject_s     = 1'b0;
`endif

   assign if_hold = ~stall & (hlt_r | inject_s);
   assign hlt     = hlt_r;

   // Register file reads with write-first bypass from WB
   always_comb begin
      ra_rd_s = (wb_en && (wb_addr == ir[3:2])) ? wb_data : regs_r[ir[3:2]];
      rb_rd_s = (wb_en && (wb_addr == ir[1:0])) ? wb_data : regs_r[ir[1:0]];
      r3_rd_s = (wb_en && (wb_addr == 2'd3))    ? wb_data : regs_r[3];
   end

   // Register file write port; keeps writing through stall and flush
   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_r[0] <= 8'h00;
         regs_r[1] <= 8'h00;
         regs_r[2] <= 8'h00;
         regs_r[3] <= SP_RESET;
      end else if (wb_en) begin
         regs_r[wb_addr] <= wb_data;
      end
   end

   // Next-state decode, priority flush > stall > halt > interrupt > IMM/NORMAL decode
   always_comb begin
      state_s     = state_r;
      first_s     = first_r;
      lat_ra_s    = lat_ra_r;
      lat_rb_s    = lat_rb_r;
      hlt_s       = hlt_r;
      ex_valid_s  = 1'b0;
      ex_int_s    = 1'b0;
      ex_opcode_s = 4'h0;
      ex_ra_s     = 2'd0;
      ex_rb_s     = 2'd0;
      ex_ra_val_s = 8'h00;
      ex_rb_val_s = 8'h00;
      ex_imm_s    = 8'h00;
      if (flush) begin
         state_s = NORMAL;
         first_s = 8'h00;
      end else if (stall) begin
         ex_valid_s  = ex_valid;
         ex_int_s    = ex_int;
         ex_opcode_s = ex_opcode;
         ex_ra_s     = ex_ra;
         ex_rb_s     = ex_rb;
         ex_ra_val_s = ex_ra_val;
         ex_rb_val_s = ex_rb_val;
         ex_imm_s    = ex_imm;
      end else if (hlt_r) begin
         state_s = state_r;
      end else if (inject_s) begin
         ex_valid_s  = 1'b1;
         ex_int_s    = 1'b1;
         ex_ra_s     = 2'd3;
         ex_rb_s     = 2'd3;
         ex_ra_val_s = r3_rd_s;
         ex_rb_val_s = r3_rd_s;
      end else begin
         case (state_r)
            IMM: begin
               ex_valid_s  = 1'b1;
               ex_opcode_s = first_r[7:4];
               ex_ra_s     = first_r[3:2];
               ex_rb_s     = first_r[1:0];
               ex_ra_val_s = lat_ra_r;
               ex_rb_val_s = lat_rb_r;
               ex_imm_s    = ir;
               state_s     = NORMAL;
            end
            NORMAL: begin
               if (ir[7:4] == TWO_BYTE_OP) begin
                  first_s  = ir;
                  lat_ra_s = ra_rd_s;
                  lat_rb_s = rb_rd_s;
                  state_s  = IMM;
               end else begin
                  ex_valid_s  = (ir[7:4] != 4'h0);
                  ex_opcode_s = ir[7:4];
                  ex_ra_s     = ir[3:2];
                  ex_rb_s     = ir[1:0];
                  ex_ra_val_s = ra_rd_s;
                  ex_rb_val_s = rb_rd_s;
                  hlt_s       = (ir == 8'h01) ? 1'b1 : hlt_r;
               end
            end
            default: begin
               state_s = NORMAL;
            end
         endcase
      end
   end

   // FSM, pair latch, halt flag and ID/EX registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= NORMAL;
         first_r   <= 8'h00;
         lat_ra_r  <= 8'h00;
         lat_rb_r  <= 8'h00;
         hlt_r     <= 1'b0;
         ex_valid  <= 1'b0;
         ex_int    <= 1'b0;
         ex_opcode <= 4'h0;
         ex_ra     <= 2'd0;
         ex_rb     <= 2'd0;
         ex_ra_val <= 8'h00;
         ex_rb_val <= 8'h00;
         ex_imm    <= 8'h00;
      end else begin
         state_r   <= state_s;
         first_r   <= first_s;
         lat_ra_r  <= lat_ra_s;
         lat_rb_r  <= lat_rb_s;
         hlt_r     <= hlt_s;
         ex_valid  <= ex_valid_s;
         ex_int    <= ex_int_s;
         ex_opcode <= ex_opcode_s;
         ex_ra     <= ex_ra_s;
         ex_rb     <= ex_rb_s;
         ex_ra_val <= ex_ra_val_s;
         ex_rb_val <= ex_rb_val_s;
         ex_imm    <= ex_imm_s;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX bundles are queued per cycle and
// checked by an independent monitor after each rising edge.
module tb_id_stage;

   logic       clk = 1'b0;
   logic       rst, stall, flush, wb_en, int_req;
   logic [7:0] ir, wb_data;
   logic [1:0] wb_addr;
   logic       if_hold, ex_valid, ex_int, hlt;
   logic [3:0] ex_opcode;
   logic [1:0] ex_ra, ex_rb;
   logic [7:0] ex_ra_val, ex_rb_val, ex_imm;

   typedef struct {
      string       tag;
      logic [34:0] b;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   id_stage dut (
      .clk(clk), .rst(rst), .ir(ir), .stall(stall), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .int_req(int_req),
      .if_hold(if_hold), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_ra_val(ex_ra_val), .ex_rb_val(ex_rb_val),
      .ex_imm(ex_imm), .ex_int(ex_int), .hlt(hlt)
   );

   always #5 clk = ~clk;

   // Bundle layout: valid, int, opcode, ra, rb, ra_val, rb_val, imm, hlt
   initial begin : monitor
      exp_t        e;
      logic [34:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {ex_valid, ex_int, ex_opcode, ex_ra, ex_rb, ex_ra_val, ex_rb_val, ex_imm, hlt};
            total++;
            if (act !== e.b) begin
               bad++;
               $display("FAIL %s: got %h want %h (v,int,op,ra,rb,ra_val,rb_val,imm,hlt)",
                        e.tag, act, e.b);
            end
         end
      end
   end

   task automatic drv(input logic rs, input logic [7:0] i, input logic st, input logic fl,
                      input logic we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic iq);
      rst = rs; ir = i; stall = st; flush = fl;
      wb_en = we; wb_addr = wa; wb_data = wd; int_req = iq;
   endtask

   task automatic exp(input string tag, input logic v, input logic it, input logic [3:0] op,
                      input logic [1:0] a, input logic [1:0] b, input logic [7:0] av,
                      input logic [7:0] bv, input logic [7:0] im, input logic h);
      exp_t e;
      e.tag = tag;
      e.b   = {v, it, op, a, b, av, bv, im, h};
      exp_q.push_back(e);
   endtask

   task automatic bub(input string tag, input logic h);
      exp(tag, 1'b0, 1'b0, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, h);
   endtask

   task automatic chk_hold(input string tag, input logic want);
      #1;
      total++;
      if (if_hold !== want) begin
         bad++;
         $display("FAIL %s: if_hold got %b want %b", tag, if_hold, want);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   initial begin : stim
      int guard;
      // reset, and reset overriding stall/flush/wb_en
      drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); bub("reset", 1'b0); step();
      drv(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 8'hAA, 1'b0); bub("reset_override", 1'b0); step();
      // bypass
      drv(1'b1, 8'h1B, 1'b0, 1'b0, 1'b1, 2'd2, 8'h5A, 1'b0);
      exp("bypass", 1'b1, 1'b0, 4'h1, 2'd2, 2'd3, 8'h5A, 8'hFF, 8'h00, 1'b0); step();
      // two-byte pair, first byte operand read through bypass
      drv(1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 2'd1, 8'h11, 1'b0); bub("pair_first", 1'b0); step();
      drv(1'b1, 8'h37, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); chk_hold("pair_if_hold", 1'b0);
      exp("pair_imm", 1'b1, 1'b0, 4'hC, 2'd1, 2'd0, 8'h11, 8'h00, 8'h37, 1'b0); step();
      // flush mid-pair
      drv(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); bub("flush_first", 1'b0); step();
      drv(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0); bub("flush_bubble", 1'b0); step();
      drv(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("after_flush", 1'b1, 1'b0, 4'h2, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); step();
      // stall with register write
      drv(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("pre_stall", 1'b1, 1'b0, 4'h2, 2'd1, 2'd1, 8'h11, 8'h11, 8'h00, 1'b0); step();
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 8'h3A, 1'b1, 1'b0, 1'b1, 2'd1, 8'h66, 1'b0); chk_hold("stall_if_hold", 1'b0);
         exp("stall_frozen", 1'b1, 1'b0, 4'h2, 2'd1, 2'd1, 8'h11, 8'h11, 8'h00, 1'b0); step();
      end
      drv(1'b1, 8'h3A, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("after_stall", 1'b1, 1'b0, 4'h3, 2'd2, 2'd2, 8'h5A, 8'h5A, 8'h00, 1'b0); step();
      drv(1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("r1_written_in_stall", 1'b1, 1'b0, 4'h4, 2'd1, 2'd1, 8'h66, 8'h66, 8'h00, 1'b0); step();
      // flush dominates stall
      drv(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); bub("fs_first", 1'b0); step();
      drv(1'b1, 8'h37, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0); bub("flush_over_stall", 1'b0); step();
      drv(1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("flush_over_stall_next", 1'b1, 1'b0, 4'h5, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); step();
      // stall between the two bytes of a pair
      drv(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); bub("sp_first", 1'b0); step();
      drv(1'b1, 8'h37, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); bub("pair_stalled", 1'b0); step();
      drv(1'b1, 8'h37, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("pair_after_stall", 1'b1, 1'b0, 4'hC, 2'd1, 2'd0, 8'h66, 8'h00, 8'h37, 1'b0); step();
      // interrupt pulse during the first byte of a pair
      drv(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1); bub("irq_first", 1'b0); step();
      drv(1'b1, 8'h37, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); chk_hold("irq_not_in_imm", 1'b0);
      exp("irq_pair_done", 1'b1, 1'b0, 4'hC, 2'd1, 2'd0, 8'h66, 8'h00, 8'h37, 1'b0); step();
`ifdef IRQ_EN
      drv(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); chk_hold("irq_if_hold", 1'b1);
      exp("irq_inject", 1'b1, 1'b1, 4'h0, 2'd3, 2'd3, 8'hFF, 8'hFF, 8'h00, 1'b0); step();
      drv(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); chk_hold("irq_hold_released", 1'b0);
      exp("irq_held_ir", 1'b1, 1'b0, 4'h2, 2'd1, 2'd1, 8'h66, 8'h66, 8'h00, 1'b0); step();
`else
      drv(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); chk_hold("int_ignored_hold", 1'b0);
      exp("int_ignored", 1'b1, 1'b0, 4'h2, 2'd1, 2'd1, 8'h66, 8'h66, 8'h00, 1'b0); step();
`endif
      // halt: sticky through later loads and flush, cleared by reset
      drv(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("hlt_decode", 1'b0, 1'b0, 4'h0, 2'd0, 2'd1, 8'h00, 8'h66, 8'h00, 1'b1); step();
      drv(1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); chk_hold("hlt_if_hold", 1'b1);
      bub("hlt_bubble", 1'b1); step();
      drv(1'b1, 8'h25, 1'b0, 1'b0, 1'b1, 2'd3, 8'h42, 1'b0); chk_hold("hlt_if_hold2", 1'b1);
      bub("hlt_bubble2", 1'b1); step();
      drv(1'b1, 8'h25, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0); bub("hlt_flush", 1'b1); step();
      drv(1'b0, 8'h25, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); bub("hlt_reset", 1'b0); step();
      drv(1'b1, 8'h1F, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); chk_hold("hold_cleared", 1'b0);
      exp("sp_after_reset", 1'b1, 1'b0, 4'h1, 2'd3, 2'd3, 8'hFF, 8'hFF, 8'h00, 1'b0); step();
      // opcode-0 NOPs do not halt
      drv(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("nop", 1'b0, 1'b0, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); step();
      drv(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      exp("nop_other", 1'b0, 1'b0, 4'h0, 2'd3, 2'd3, 8'hFF, 8'hFF, 8'h00, 1'b0); step();
      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the 8-bit pipelined processor, directly downstream of the fetch-stage instruction register. Each cycle it takes the 8-bit IR and decodes it. It reads the 4×8 register file, where R3 is SP, and writes back from the WB stage. It assembles two-byte instructions from consecutive IR values, tracks halt, and optionally injects interrupt pseudo-instructions. It loads a registered ID/EX bundle consumed by the execute stage.

## Interface
Parameters:
- SP_RESET, 8'hFF: reset value of R3 (stack pointer).
- TWO_BYTE_OP, 4'hC: opcode whose instructions carry a second (immediate/address) byte.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets).
- ir  in  8  instruction byte from IR; [7:4] opcode, [3:2] ra, [1:0] rb.
- stall  in  1  hazard-unit stall; freezes ID/EX outputs, FSM, pending-int latch.
- flush  in  1  squash: next ID/EX is a bubble, FSM to NORMAL; dominates stall.
- wb_en  in  1  register-file write enable.
- wb_addr  in  2  write register index.
- wb_data  in  8  write data.
- int  in  1  external interrupt request (used only with IRQ_EN).
- if_hold  out  1  combinational; tells fetch to hold PC and IR this cycle.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_opcode  out  4  decoded opcode.
- ex_ra, ex_rb  out  2 each  register indices.
- ex_ra_val, ex_rb_val  out  8 each  operand values.
- ex_imm  out  8  second byte of a two-byte instruction, else 0.
- ex_int  out  1  ID/EX slot is an interrupt pseudo-instruction.
- hlt  out  1  sticky halt flag.

## Operation
- Register file: R0..R3, 8 bits. Write on the rising edge when wb_en. Reads are combinational with write-first bypass: a read index equal to wb_addr while wb_en returns wb_data.
- NOP is ir==8'h00. HLT is ir==8'h01. Any other opcode-0 value is also a NOP.
- FSM states are NORMAL and IMM.
- NORMAL, opcode != TWO_BYTE_OP:
  - Load ID/EX from ir and register reads.
  - ex_valid=1 unless NOP/HLT.
  - ex_imm=0.
- NORMAL, opcode == TWO_BYTE_OP:
  - Latch the first byte and both operand values.
  - Load a bubble (ex_valid=0).
  - Go to IMM.
- IMM: the current ir is the immediate.
  - Load ID/EX from the latched first byte with ex_imm=ir and ex_valid=1.
  - Go to NORMAL.
  - The immediate byte is never decoded as an opcode.
- HLT in NORMAL sets hlt=1, which holds until reset. While hlt=1, every ID/EX load is a bubble and if_hold=1.
- stall=1: nothing updates, except that the register file still writes.
- flush=1:
  - ID/EX becomes a bubble.
  - FSM goes to NORMAL and any latched first byte is discarded.
  - hlt is unaffected.
- Bubble means ex_valid=0, ex_int=0, ex_opcode=0, ex_ra/ex_rb=0, ex_ra_val/ex_rb_val=0, ex_imm=0.

## Timing
- Reset (rst==0 at an edge):
  - R0..R2=0, R3=SP_RESET.
  - FSM NORMAL, hlt=0, int_pending=0.
  - All ex_* outputs 0.
  - Reset overrides stall, flush and wb_en in that cycle.
- Latency: one-byte instruction, ir present at edge N → ID/EX valid after edge N.
- Two-byte instruction: first byte at edge N, immediate at edge N+1 → valid after N+1, with a bubble after N.
- A write at edge N is seen by a decode at edge N through the bypass.
- Priority, highest first: rst, flush, stall, hlt, interrupt injection, normal decode.
- if_hold = hlt | (interrupt injection this cycle). It is never asserted while stall=1; the hazard unit holds fetch in that case.

## Configuration
- IRQ_EN defined:
  - int is latched into int_pending on any cycle it is 1.
  - When FSM=NORMAL, stall=0, flush=0 and hlt=0 with int_pending=1, the stage loads ID/EX with ex_int=1, ex_valid=1, ex_opcode=0, ex_ra=ex_rb=3, ex_ra_val=ex_rb_val=R3 (value after bypass).
  - In that cycle it asserts if_hold=1 so the current ir is kept and decoded next cycle.
  - int_pending is cleared by that injection.
  - No injection occurs in IMM, so two-byte instructions are atomic.
  - An int during hlt stays pending; it does not wake the core.
- IRQ_EN undefined: int is ignored, int_pending does not exist, ex_int is tied 0, and if_hold=hlt.

## Test plan
- Reset and bypass:
  - Stimulus: rst=0 for 2 cycles, then ir=8'h1B (op1, ra=2, rb=3) with wb_en=1, wb_addr=2, wb_data=8'h5A in the same cycle.
  - Required response: ex_valid=1, ex_opcode=1, ex_ra_val=8'h5A, ex_rb_val=8'hFF.
- Two-byte instruction:
  - Stimulus: ir=8'hC4 then ir=8'h37.
  - Required response: first cycle a bubble; next cycle ex_opcode=4'hC, ex_ra=1, ex_rb=0, ex_imm=8'h37, and 8'h37 is not decoded as an opcode.
- Flush mid-pair:
  - Stimulus: ir=8'hC4, then flush=1 in the next cycle.
  - Required response: bubble, FSM NORMAL; the following ir=8'h20 decodes as opcode 2.
- Halt:
  - Stimulus: ir=8'h01, then ir=8'h15.
  - Required response: hlt=1, if_hold=1, every later load a bubble; rst=0 clears hlt to 0.
- Stall:
  - Stimulus: ir=8'h25 decoded, then stall=1 for 3 cycles with ir=8'h3A and wb_en=1 to R1.
  - Required response: ex_* unchanged for 3 cycles; R1 updated; after release ir=8'h3A decodes.
- IRQ_EN:
  - Stimulus: int pulsed 1 cycle while ir=8'hC4.
  - Required response: the immediate completes first; then ex_int=1, ex_ra_val=8'hFF, if_hold=1 for one cycle; then the held ir decodes normally.
